// File: rtl/cpu_pkg.sv
// Shared definitions for the 3-stage CPU: default widths, NOP encoding and
// fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 16;

  localparam logic [15:0] NopInsn = 16'h0000;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read handshake between the fetch unit (master) and
// program memory (slave).
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/fetch_timer.sv
// Counts WAIT cycles of an outstanding fetch; expired flags the last cycle
// the fetch is allowed to wait for an acknowledge.
module fetch_timer #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic ce,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(ACK_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (ce) begin
      if (start) begin
        cnt_q <= '0;
      end else if (run) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign expired = (cnt_q == LastCnt);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns pc and ir, issues one handshaked read per f
// phase and stalls the phase counter while the read is outstanding.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W      = DefAddrW,
  parameter int unsigned         DATA_W      = DefDataW,
  parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
  parameter logic [DATA_W-1:0]   NOP         = DATA_W'(NopInsn),
  parameter int unsigned         ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ce,
  input  logic              f,
  input  logic              i,
  input  logic              br_ld,
  input  logic [ADDR_W-1:0] br_addr,
  fetch_unit_if.master      mem,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              stall,
  output logic              err
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic              ir_valid_q;
  logic              err_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic timer_start;
  logic timer_run;
  logic timer_expired;

  assign timer_start = (state_q == StIdle) && f;
  assign timer_run   = (state_q == StWait) && !mem.mem_ack && !timer_expired;

  fetch_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_fetch_timer (
    .clk     (clk),
    .clr     (clr),
    .ce      (ce),
    .start   (timer_start),
    .run     (timer_run),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      ir_q       <= NOP;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (ce) begin
      // pc may move during WAIT; the captured mem_addr is independent of it.
      if (i) begin
        pc_q <= br_ld ? br_addr : pc_q + ADDR_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (f) begin
            state_q    <= StWait;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
            ir_valid_q <= 1'b0;
          end
        end
        StWait: begin
          if (mem.mem_ack) begin
            state_q    <= StIdle;
            ir_q       <= mem.mem_rdata;
            ir_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
          end else if (timer_expired) begin
            state_q    <= StIdle;
            ir_q       <= NOP;
            ir_valid_q <= 1'b1;
            err_q      <= 1'b1;
            mem_req_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign pc           = pc_q;
  assign ir           = ir_q;
  assign ir_valid     = ir_valid_q;
  assign err          = err_q;
  assign stall        = (state_q == StWait);

endmodule
